// File: rtl/riscv_alu_arbiter_if.sv
// Requester, response and ALU-side signals of riscv_alu_arbiter, named from the arbiter's view.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface riscv_alu_arbiter_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OP_W = 6
);
    logic            r0_valid_i;
    logic            r0_ready_o;
    logic [OP_W-1:0] r0_op_i;
    logic [XLEN-1:0] r0_a_i;
    logic [XLEN-1:0] r0_b_i;
    logic            r0_rsp_valid_o;
    logic            r0_rsp_ready_i;

    logic            r1_valid_i;
    logic            r1_ready_o;
    logic [OP_W-1:0] r1_op_i;
    logic [XLEN-1:0] r1_a_i;
    logic [XLEN-1:0] r1_b_i;
    logic            r1_rsp_valid_o;
    logic            r1_rsp_ready_i;

    logic [XLEN-1:0] rsp_result_o;
    logic            rsp_flag_o;
    logic            rsp_err_o;

    logic [OP_W-1:0] alu_operator_o;
    logic [XLEN-1:0] alu_operand_a_o;
    logic [XLEN-1:0] alu_operand_b_o;
    logic [XLEN-1:0] alu_result_i;
    logic            alu_flag_i;

    modport slave (
        input  r0_valid_i, r0_op_i, r0_a_i, r0_b_i, r0_rsp_ready_i,
        input  r1_valid_i, r1_op_i, r1_a_i, r1_b_i, r1_rsp_ready_i,
        input  alu_result_i, alu_flag_i,
        output r0_ready_o, r0_rsp_valid_o, r1_ready_o, r1_rsp_valid_o,
        output rsp_result_o, rsp_flag_o, rsp_err_o,
        output alu_operator_o, alu_operand_a_o, alu_operand_b_o
    );

    modport master (
        output r0_valid_i, r0_op_i, r0_a_i, r0_b_i, r0_rsp_ready_i,
        output r1_valid_i, r1_op_i, r1_a_i, r1_b_i, r1_rsp_ready_i,
        output alu_result_i, alu_flag_i,
        input  r0_ready_o, r0_rsp_valid_o, r1_ready_o, r1_rsp_valid_o,
        input  rsp_result_o, rsp_flag_o, rsp_err_o,
        input  alu_operator_o, alu_operand_a_o, alu_operand_b_o
    );
endinterface

// File: rtl/riscv_alu_arbiter.sv
// Round-robin sharing of one combinational riscV_alu between two requesters.
// One operation in flight: accept (IDLE) -> ALU evaluates (EXEC) -> held response (RESP).
module riscv_alu_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OP_W = 6
) (
    input logic               clk_i,
    input logic               rst_i,
    riscv_alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    localparam logic [OP_W-1:0] ALU_ADD = '0;

    state_e          state_q;
    logic            last_grant_q;
    logic            owner_q;
    logic            illegal_q;
    logic [OP_W-1:0] op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] result_q;
    logic            flag_q;
    logic            err_q;
    logic            r0_rsp_valid_q;
    logic            r1_rsp_valid_q;

    logic            gnt0;
    logic            gnt1;
    logic            sel_legal;
    logic [OP_W-1:0] sel_op;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        logic ok;
        case (op[4:0])
            5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011,
            5'b00100, 5'b00101, 5'b01101, 5'b00110, 5'b00111,
            5'b11000, 5'b11001, 5'b11101, 5'b11111: ok = 1'b1;
            default:                                 ok = 1'b0;
        endcase
        return ok && ((op >> 5) == '0);
    endfunction

    // Tie goes to whichever requester was not served last; grants are masked while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE && !rst_i) begin
            gnt0 = bus.r0_valid_i & (~bus.r1_valid_i | last_grant_q);
            gnt1 = bus.r1_valid_i & (~bus.r0_valid_i | ~last_grant_q);
        end
        sel_op    = gnt1 ? bus.r1_op_i : bus.r0_op_i;
        sel_a     = gnt1 ? bus.r1_a_i  : bus.r0_a_i;
        sel_b     = gnt1 ? bus.r1_b_i  : bus.r0_b_i;
        sel_legal = op_legal(sel_op);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            illegal_q      <= 1'b0;
            op_q           <= ALU_ADD;
            a_q            <= '0;
            b_q            <= '0;
            result_q       <= '0;
            flag_q         <= 1'b0;
            err_q          <= 1'b0;
            r0_rsp_valid_q <= 1'b0;
            r1_rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        state_q      <= EXEC;
                        owner_q      <= gnt1;
                        last_grant_q <= gnt1;
                        illegal_q    <= ~sel_legal;
                        op_q         <= sel_legal ? sel_op : ALU_ADD;
                        a_q          <= sel_legal ? sel_a  : '0;
                        b_q          <= sel_legal ? sel_b  : '0;
                    end
                end
                EXEC: begin
                    state_q        <= RESP;
                    result_q       <= illegal_q ? '0 : bus.alu_result_i;
                    flag_q         <= illegal_q ? 1'b0 : bus.alu_flag_i;
                    err_q          <= illegal_q;
                    r0_rsp_valid_q <= ~owner_q;
                    r1_rsp_valid_q <= owner_q;
                end
                RESP: begin
                    if (owner_q ? bus.r1_rsp_ready_i : bus.r0_rsp_ready_i) begin
                        state_q        <= IDLE;
                        r0_rsp_valid_q <= 1'b0;
                        r1_rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.r0_ready_o      = gnt0;
    assign bus.r1_ready_o      = gnt1;
    assign bus.r0_rsp_valid_o  = r0_rsp_valid_q;
    assign bus.r1_rsp_valid_o  = r1_rsp_valid_q;
    assign bus.rsp_result_o    = result_q;
    assign bus.rsp_flag_o      = flag_q;
    assign bus.rsp_err_o       = err_q;
    assign bus.alu_operator_o  = op_q;
    assign bus.alu_operand_a_o = a_q;
    assign bus.alu_operand_b_o = b_q;
endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Self-checking bench for riscv_alu_arbiter: directed test-plan steps, then random traffic.
// The bench also plays the combinational riscV_alu behind the arbiter.
module tb_riscv_alu_arbiter;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   last = 1;

    riscv_alu_arbiter_if #(.XLEN(32), .OP_W(6)) bus();

    riscv_alu_arbiter #(.XLEN(32), .OP_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b001000, SRA = 6'b001101,
                           LTS = 6'b000010, EQ = 6'b011000, GEU = 6'b011111;
    logic [5:0] legal_ops [14] = '{6'b000000, 6'b001000, 6'b000001, 6'b000010, 6'b000011,
                                   6'b000100, 6'b000101, 6'b001101, 6'b000110, 6'b000111,
                                   6'b011000, 6'b011001, 6'b011101, 6'b011111};

    logic [5:0]  op_r [2];
    logic [31:0] a_r  [2];
    logic [31:0] b_r  [2];

    // Model of the ALU: {flag, result}; comparisons return the condition in both.
    function automatic logic [32:0] alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic c;
        c = 1'b0;
        case (op)
            6'b000000: return {1'b0, a + b};
            6'b001000: return {1'b0, a - b};
            6'b000001: return {1'b0, a << b[4:0]};
            6'b000100: return {1'b0, a ^ b};
            6'b000101: return {1'b0, a >> b[4:0]};
            6'b001101: return {1'b0, 32'($signed(a) >>> b[4:0])};
            6'b000110: return {1'b0, a | b};
            6'b000111: return {1'b0, a & b};
            6'b000010: c = $signed(a) < $signed(b);
            6'b000011: c = a < b;
            6'b011000: c = a == b;
            6'b011001: c = a != b;
            6'b011101: c = $signed(a) >= $signed(b);
            6'b011111: c = a >= b;
            default:   return 33'd0;
        endcase
        return {c, 31'd0, c};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    always_comb {bus.alu_flag_i, bus.alu_result_i} = alu(bus.alu_operator_o, bus.alu_operand_a_o, bus.alu_operand_b_o);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        bus.r0_valid_i = 1'b0;
        bus.r1_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy0", bus.r0_ready_o, 0);
        chk("rst_rdy1", bus.r1_ready_o, 0);
        chk("rst_rv0", bus.r0_rsp_valid_o, 0);
        chk("rst_rv1", bus.r1_rsp_valid_o, 0);
        chk("rst_res", bus.rsp_result_o, 0);
        chk("rst_flag", bus.rsp_flag_o, 0);
        chk("rst_err", bus.rsp_err_o, 0);
        chk("rst_aluop", bus.alu_operator_o, 0);
        rst_i = 1'b0;
        last = 1;
    endtask

    // One transaction: present the requests, predict the winner, follow it to the handshake.
    task automatic txn(input bit v0, input bit v1, input int hold);
        int w;
        logic [32:0] exp;
        bit lg;
        w = (v0 && v1) ? (last == 0 ? 1 : 0) : (v0 ? 0 : 1);
        lg = is_legal(op_r[w]);
        exp = lg ? alu(op_r[w], a_r[w], b_r[w]) : 33'd0;
        bus.r0_valid_i = v0; bus.r0_op_i = op_r[0]; bus.r0_a_i = a_r[0]; bus.r0_b_i = b_r[0];
        bus.r1_valid_i = v1; bus.r1_op_i = op_r[1]; bus.r1_a_i = a_r[1]; bus.r1_b_i = b_r[1];
        bus.r0_rsp_ready_i = 1'b1;
        bus.r1_rsp_ready_i = 1'b1;
        #1;
        chk("acc_rdy0", bus.r0_ready_o, 32'(w == 0));
        chk("acc_rdy1", bus.r1_ready_o, 32'(w == 1));
        @(posedge clk); #1;
        last = w;
        if (w == 0) begin
            bus.r0_valid_i = 1'b0; bus.r0_op_i = 6'($urandom); bus.r0_a_i = $urandom; bus.r0_b_i = $urandom;
        end else begin
            bus.r1_valid_i = 1'b0; bus.r1_op_i = 6'($urandom); bus.r1_a_i = $urandom; bus.r1_b_i = $urandom;
        end
        chk("exec_op", bus.alu_operator_o, lg ? 32'(op_r[w]) : 0);
        chk("exec_a", bus.alu_operand_a_o, lg ? a_r[w] : 0);
        chk("exec_b", bus.alu_operand_b_o, lg ? b_r[w] : 0);
        chk("exec_rdy", {bus.r0_ready_o, bus.r1_ready_o}, 0);
        chk("exec_rv", {bus.r0_rsp_valid_o, bus.r1_rsp_valid_o}, 0);
        if (hold > 0) begin
            if (w == 0) bus.r0_rsp_ready_i = 1'b0; else bus.r1_rsp_ready_i = 1'b0;
        end
        @(posedge clk); #1;
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) begin
                bus.r0_rsp_ready_i = 1'b1;
                bus.r1_rsp_ready_i = 1'b1;
            end
            chk("rsp_rv", {bus.r0_rsp_valid_o, bus.r1_rsp_valid_o}, w == 0 ? 2'b10 : 2'b01);
            chk("rsp_res", bus.rsp_result_o, exp[31:0]);
            chk("rsp_flag", bus.rsp_flag_o, 32'(exp[32]));
            chk("rsp_err", bus.rsp_err_o, 32'(!lg));
            chk("rsp_rdy", {bus.r0_ready_o, bus.r1_ready_o}, 0);
            @(posedge clk); #1;
        end
        chk("done_rv", {bus.r0_rsp_valid_o, bus.r1_rsp_valid_o}, 0);
        chk("done_hold", bus.rsp_result_o, exp[31:0]);
    endtask

    task automatic set_req(input int k, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        op_r[k] = op; a_r[k] = a; b_r[k] = b;
    endtask

    initial begin
        bus.r0_valid_i = 1'b0; bus.r0_op_i = '0; bus.r0_a_i = '0; bus.r0_b_i = '0; bus.r0_rsp_ready_i = 1'b1;
        bus.r1_valid_i = 1'b0; bus.r1_op_i = '0; bus.r1_a_i = '0; bus.r1_b_i = '0; bus.r1_rsp_ready_i = 1'b1;
        set_req(0, ADD, 0, 0);
        set_req(1, ADD, 0, 0);
        apply_reset();

        set_req(0, ADD, 5, 7);
        txn(1, 0, 0);

        apply_reset();
        set_req(0, EQ, 3, 3);
        set_req(1, SUB, 10, 4);
        txn(1, 1, 0);
        txn(1, 1, 0);
        txn(1, 1, 0);

        set_req(1, SRA, 32'h8000_0000, 4);
        txn(1, 1, 5);

        set_req(0, 6'b001010, 32'h1234, 32'h5678);
        txn(1, 0, 0);
        set_req(0, LTS, 32'hFFFF_FFFF, 1);
        txn(1, 0, 0);
        set_req(0, GEU, 32'hFFFF_FFFF, 1);
        txn(1, 0, 0);

        // Reset during req1's response with req0 pending; req0 must win afterwards.
        bus.r0_valid_i = 1'b1; bus.r0_op_i = ADD; bus.r0_a_i = 1; bus.r0_b_i = 2;
        bus.r1_valid_i = 1'b1; bus.r1_op_i = SUB; bus.r1_a_i = 9; bus.r1_b_i = 3;
        bus.r1_rsp_ready_i = 1'b0;
        #1;
        chk("pre_rdy1", bus.r1_ready_o, 1);
        @(posedge clk); #1;
        bus.r1_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("pre_rv1", bus.r1_rsp_valid_o, 1);
        chk("pre_res", bus.rsp_result_o, 6);
        rst_i = 1'b1;
        #1;
        chk("arst_rv1", bus.r1_rsp_valid_o, 0);
        chk("arst_rdy", {bus.r0_ready_o, bus.r1_ready_o}, 0);
        chk("arst_res", bus.rsp_result_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        last = 1;
        set_req(0, ADD, 1, 2);
        set_req(1, SUB, 9, 3);
        txn(1, 1, 0);

        for (int i = 0; i < 40; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            for (int k = 0; k < 2; k++) begin
                logic [5:0] op;
                op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 13)];
                set_req(k, op, $urandom, $urandom);
            end
            txn(pat[0], pat[1], $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
